// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared types for the UART transmit side that drains the processor-to-UART FIFO.
package uart_tx_fifo_drain_pkg;

    typedef logic bit_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int UART_DATA_W = 8;

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// Read-side FIFO port: master is the draining UART, slave is the FIFO storage.
interface uart_tx_fifo_drain_if
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int DATA_W    = UART_DATA_W,
    parameter int ADDR_BITS = 4
);

    logic                 fifo_empty;
    logic [DATA_W-1:0]    fifo_rdata;
    logic                 fifo_rd;
    logic [ADDR_BITS-1:0] r_add;

    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        output fifo_rd,
        output r_add
    );

    modport slave (
        output fifo_empty,
        output fifo_rdata,
        input  fifo_rd,
        input  r_add
    );

endinterface

// File: rtl/uart_tx_fifo_drain_baud_tick.sv
// Bit-period counter: one-cycle pulse on the last clock of each UART bit.
module uart_tx_fifo_drain_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q;

    assign tick = enable && (count_q == TERMINAL);

    // Clear wins so a new frame always starts with a full-length start bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= tick ? '0 : count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Pops bytes from the TX FIFO and serialises each as an 8N1/8E1 frame on tx,
// owning the FIFO read pointer that the processor side Gray-synchronises.
module uart_tx_fifo_drain
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int DATA_W       = UART_DATA_W,
    parameter int ADDR_BITS    = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tx_enable,
    uart_tx_fifo_drain_if.master  fifo,
    output logic                  tx,
    output logic                  busy
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    tx_state_e            state_q, state_d;
    logic [DATA_W-1:0]    shift_q, shift_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    bit_t                 parity_q, parity_d;
    logic [ADDR_BITS-1:0] r_add_q, r_add_d;
    bit_t                 tx_q, tx_d;
    logic                 tick;
    logic                 frame_end;
    logic                 pop;

    uart_tx_fifo_drain_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock (clock),
        .reset (reset),
        .enable(state_q != IDLE),
        .clear (pop),
        .tick  (tick)
    );

    assign frame_end = (state_q == STOP) && tick;
    // Gated by reset so no pop strobe reaches the FIFO while it is held in reset.
    assign pop = reset && tx_enable && !fifo.fifo_empty &&
                 ((state_q == IDLE) || frame_end);

    // tx is registered from its next value so the line changes on the same edge as the state.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        parity_d = parity_q;
        r_add_d  = r_add_q;
        tx_d     = tx_q;

        case (state_q)
            START: begin
                if (tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + BIT_W'(1);
                        tx_d    = shift_d[0];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                tx_d = 1'b1;
            end
        endcase

        // A pop at the end of STOP chains straight into the next start bit.
        if (pop) begin
            state_d  = START;
            shift_d  = fifo.fifo_rdata;
            parity_d = ^fifo.fifo_rdata;
            r_add_d  = r_add_q + ADDR_BITS'(1);
            bit_d    = '0;
            tx_d     = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            parity_q <= 1'b0;
            r_add_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            parity_q <= parity_d;
            r_add_q  <= r_add_d;
            tx_q     <= tx_d;
        end
    end

    assign fifo.fifo_rd = pop;
    assign fifo.r_add   = r_add_q;
    assign tx           = tx_q;
    assign busy         = (state_q != IDLE);

endmodule
